hdr_parser_engine: RTL

- Parametrised, reconfigurable header-walk engine: the next generation of the packet parser inside proc.
- Walks a packet held in packet memory through the shared mem port (ce/we/addr/width/data), one header at a time. For each header it fetches the next-header tag, looks it up in a runtime-programmable per-header next table, and records each parsed header's byte offset.
- Adds over the previous parser: parametrised header count, next-table depth and parse depth; loop/depth error detection; config lockout while busy; a random-access offset query port for the matcher.

---
 rtl/hdr_parser_engine.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hdr_parser_engine.sv
// Header-walk parser: follows next-header tags through packet memory using a
// runtime-programmed per-header next table and records each header's byte offset.
module hdr_parser_engine #(
  parameter int  HDR_NUM         = 16,
  parameter int  NEXT_TABLE_SIZE = 4,
  parameter int  MAX_DEPTH       = 8,
  parameter int  ADDR_W          = 32,
  parameter int  DATA_W          = 32,
  localparam int ID_W            = $clog2(HDR_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            pkt_addr_i,
  input  logic [ID_W-1:0]              first_hdr_id_i,
  output logic                         ready_o,
  output logic                         busy_o,
  output logic                         error_o,
  output logic                         mem_ce_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [3:0]                   mem_width_o,
  input  logic [DATA_W-1:0]            mem_data_i,
  input  logic                         mod_start_i,
  input  logic [ID_W-1:0]              mod_hdr_id_i,
  input  logic [7:0]                   mod_hdr_len_i,
  input  logic [7:0]                   mod_next_tag_start_i,
  input  logic [2:0]                   mod_next_tag_len_i,
  input  logic [32*NEXT_TABLE_SIZE-1:0] mod_next_table_i,
  input  logic [ID_W-1:0]              query_hdr_id_i,
  output logic                         query_valid_o,
  output logic [15:0]                  query_off_o,
  output logic [2:0]                   dbg_state_o
);

  // Handshake: start_i is accepted on any clock edge seen in IDLE; busy_o rises on
  // that edge and falls on the same edge that raises the one-cycle ready_o pulse.
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOOKUP, DONE} state_t;

  localparam int DEP_W = $clog2(MAX_DEPTH + 1);

  state_t                   state;
  logic [ADDR_W-1:0]        base;
  logic [ID_W-1:0]          cur_id;
  logic [15:0]              off;
  logic [DEP_W-1:0]         depth;
  logic [15:0]              tag;

  logic [HDR_NUM-1:0][7:0]  cfg_len;
  logic [HDR_NUM-1:0][7:0]  cfg_ts;
  logic [HDR_NUM-1:0][2:0]  cfg_tlen;
  logic [HDR_NUM-1:0][NEXT_TABLE_SIZE-1:0][31:0] cfg_tab;

  logic [HDR_NUM-1:0]       hdr_vld;
  logic [HDR_NUM-1:0][15:0] hdr_off;

  logic [7:0]               cur_len;
  logic [7:0]               cur_ts;
  logic [2:0]               cur_tlen;
  logic                     hit;
  logic [ID_W-1:0]          hit_id;
  logic                     unused_data;

  assign cur_len     = cfg_len[cur_id];
  assign cur_ts      = cfg_ts[cur_id];
  assign cur_tlen    = cfg_tlen[cur_id];
  assign mem_we_o    = 1'b0;
  assign dbg_state_o = state;
  assign unused_data = ^mem_data_i[DATA_W-1:16];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = NEXT_TABLE_SIZE - 1; i >= 0; i--) begin
      if (cfg_tab[cur_id][i][15:0] != 16'hFFFF &&
          {16'h0, cfg_tab[cur_id][i][15:0]} < 32'(HDR_NUM) &&
          cfg_tab[cur_id][i][31:16] == tag) begin
        hit    = 1'b1;
        hit_id = cfg_tab[cur_id][i][ID_W-1:0];
      end
    end
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    if (state == FETCH && cur_tlen != 3'd0 && cur_tlen <= 3'd2) begin
      mem_ce_o    = 1'b1;
      mem_addr_o  = base + ADDR_W'(off) + ADDR_W'(cur_ts);
      mem_width_o = {1'b0, cur_tlen};
    end
  end

  always_comb begin
    query_valid_o = 1'b0;
    query_off_o   = '0;
    if (int'(query_hdr_id_i) < HDR_NUM && hdr_vld[query_hdr_id_i]) begin
      query_valid_o = 1'b1;
      query_off_o   = hdr_off[query_hdr_id_i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      error_o  <= 1'b0;
      base     <= '0;
      cur_id   <= '0;
      off      <= '0;
      depth    <= '0;
      tag      <= '0;
      cfg_len  <= '0;
      cfg_ts   <= '0;
      cfg_tlen <= '0;
      cfg_tab  <= '1;
      hdr_vld  <= '0;
      hdr_off  <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mod_start_i) begin
            cfg_len[mod_hdr_id_i]  <= mod_hdr_len_i;
            cfg_ts[mod_hdr_id_i]   <= mod_next_tag_start_i;
            cfg_tlen[mod_hdr_id_i] <= mod_next_tag_len_i;
            cfg_tab[mod_hdr_id_i]  <= mod_next_table_i;
          end
          if (start_i) begin
            base    <= pkt_addr_i;
            cur_id  <= first_hdr_id_i;
            off     <= '0;
            depth   <= DEP_W'(1);
            hdr_vld <= '0;
            error_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          hdr_vld[cur_id] <= 1'b1;
          hdr_off[cur_id] <= off;
          if (cur_tlen == 3'd0) begin
            state <= DONE;
          end else if (cur_tlen > 3'd2) begin
            error_o <= 1'b1;
            state   <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          tag   <= (cur_tlen == 3'd1) ? {8'h00, mem_data_i[7:0]} : mem_data_i[15:0];
          state <= LOOKUP;
        end
        LOOKUP: begin
          if (!hit) begin
            state <= DONE;
          end else if (hdr_vld[hit_id] || depth == DEP_W'(MAX_DEPTH)) begin
            error_o <= 1'b1;
            state   <= DONE;
          end else begin
            off    <= off + {8'h00, cur_len};
            depth  <= depth + DEP_W'(1);
            cur_id <= hit_id;
            state  <= FETCH;
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
